// File: rtl/jtag_driver.sv
// jtag_driver: clocked JTAG master issuing TAP reset, IR/DR scans and idle
// cycles RTI-to-RTI; ports: cmd_* request, rsp_* capture, tck/tms/tdi/trst_n/tdo.
module jtag_driver #(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst_n,
  input  logic               tdo
);

  localparam int CNT_W = $clog2(MAX_LEN + 8);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int SI_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_LOAD, S_LO, S_HI
  } state_e;

  typedef struct packed {
    logic            tms;
    logic            shift;
    logic [SI_W-1:0] idx;
  } bit_t;

  // Bit b of a command: optional TLR->RTI prefix, header,
  // shift bits, then Exit1 -> Update -> RTI.
  function automatic bit_t decode_bit(
    input logic [1:0]       op,
    input logic             pre,
    input logic [CNT_W-1:0] n,
    input logic [CNT_W-1:0] b
  );
    bit_t r;
    logic [CNT_W-1:0] j;
    logic [CNT_W-1:0] h;
    r = '0;
    j = b - CNT_W'(pre);
    h = (op == 2'd1) ? CNT_W'(4) : CNT_W'(3);
    if (pre && b == '0) begin
      r.tms = 1'b0;
    end else begin
      unique case (1'b1)
        op == 2'd0: r.tms = (j != CNT_W'(5));
        op == 2'd3: r.tms = 1'b0;
        default: begin
          if (j < h) begin
            r.tms = (op == 2'd1) ? (j < CNT_W'(2)) : (j == '0);
          end else if (j < h + n) begin
            r.shift = 1'b1;
            r.idx   = SI_W'(j - h);
            r.tms   = (j == h + n - 1'b1);
          end else begin
            r.tms = (j == h + n);
          end
        end
      endcase
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_n_q, trst_n_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               pre_q, pre_d;
  logic [CNT_W-1:0]   nbits_q, nbits_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tlr_q, tlr_d;
  logic               shift_q, shift_d;
  logic [SI_W-1:0]    sidx_q, sidx_d;

  logic [LEN_W-1:0]   len_c;
  logic [CNT_W-1:0]   len_n;
  logic [CNT_W-1:0]   body_c;
  logic [CNT_W-1:0]   nbits_c;
  logic               pre_c;
  logic [CNT_W-1:0]   nb;
  bit_t               nxt;
  logic               ld;
  logic               fin;

  assign len_c = (cmd_len > LEN_W'(MAX_LEN)) ?
                 LEN_W'(MAX_LEN) : cmd_len;
  assign len_n = CNT_W'(len_c);
  // Leaving TLR needs one TMS=0 bit; an empty idle skips it.
  assign pre_c = tlr_q && (cmd_op != 2'd0) &&
                 !(cmd_op == 2'd3 && len_c == '0);

  always_comb begin
    body_c = '0;
    unique case (cmd_op)
      2'd0: body_c = CNT_W'(6);
      2'd1: body_c = (len_n == '0) ? '0 : len_n + CNT_W'(6);
      2'd2: body_c = (len_n == '0) ? '0 : len_n + CNT_W'(5);
      2'd3: body_c = len_n;
    endcase
  end

  assign nbits_c = body_c + CNT_W'(pre_c);
  assign nb  = (state_q == S_LOAD) ? '0 : bit_q + 1'b1;
  assign nxt = decode_bit(op_q, pre_q, len_q, nb);

  always_comb begin
    state_d     = state_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_n_d    = 1'b1;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    cap_d       = cap_q;
    data_d      = data_q;
    op_d        = op_q;
    len_d       = len_q;
    pre_d       = pre_q;
    nbits_d     = nbits_q;
    bit_d       = bit_q;
    div_d       = div_q;
    tlr_d       = tlr_q;
    shift_d     = shift_q;
    sidx_d      = sidx_q;
    ld          = 1'b0;
    fin         = 1'b0;
    unique case (state_q)
      S_RST: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          len_d       = len_n;
          data_d      = cmd_data;
          pre_d       = pre_c;
          nbits_d     = nbits_c;
          cap_d       = '0;
          cmd_ready_d = 1'b0;
          tlr_d       = tlr_q && (nbits_c == '0);
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (nbits_q == '0) fin = 1'b1;
        else               ld  = 1'b1;
      end
      S_LO: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          tck_d   = 1'b1;
          div_d   = '0;
          state_d = S_HI;
          if (shift_q) cap_d[sidx_q] = tdo;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HI: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          tck_d = 1'b0;
          if (bit_q == nbits_q - 1'b1) fin = 1'b1;
          else                         ld  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_RST;
    endcase
    if (ld) begin
      tms_d   = nxt.tms;
      tdi_d   = nxt.shift ? data_q[nxt.idx] : 1'b0;
      shift_d = nxt.shift;
      sidx_d  = nxt.idx;
      bit_d   = nb;
      div_d   = '0;
      state_d = S_LO;
    end
    if (fin) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = cap_q;
      cmd_ready_d = 1'b1;
      shift_d     = 1'b0;
      div_d       = '0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_n_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cap_q       <= '0;
      data_q      <= '0;
      op_q        <= '0;
      len_q       <= '0;
      pre_q       <= 1'b0;
      nbits_q     <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      tlr_q       <= 1'b1;
      shift_q     <= 1'b0;
      sidx_q      <= '0;
    end else begin
      state_q     <= state_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_n_q    <= trst_n_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cap_q       <= cap_d;
      data_q      <= data_d;
      op_q        <= op_d;
      len_q       <= len_d;
      pre_q       <= pre_d;
      nbits_q     <= nbits_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      tlr_q       <= tlr_d;
      shift_q     <= shift_d;
      sidx_q      <= sidx_d;
    end
  end

  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign trst_n    = trst_n_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_driver.sv
// tb_jtag_driver: directed bench for jtag_driver with a behavioural TAP,
// tck/tms/tdi history and a response scoreboard.
module tb_jtag_driver;

  localparam int MAX_LEN = 32;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = '0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck, tms, tdi, trst_n, tdo;

  jtag_driver #(
    .MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .trst_n(trst_n), .tdo(tdo)
  );

  always #5 clk = ~clk;

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  tap_e        st;
  logic [31:0] sr;
  logic [31:0] dr_cap = '0;
  logic        tie1 = 1'b0;
  logic        tdo_m;
  int          tck_cnt;
  logic        tms_hist [0:1023];
  logic        tdi_hist [0:1023];

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      st <= TLR;
    end else begin
      tms_hist[tck_cnt[9:0]] <= tms;
      tdi_hist[tck_cnt[9:0]] <= tdi;
      tck_cnt <= tck_cnt + 1;
      if (st == SHDR || st == SHIR) sr <= {tdi, sr[31:1]};
      else if (st == CAPDR)         sr <= dr_cap;
      else if (st == CAPIR)         sr <= 32'h1;
      st <= tap_next(st, tms);
    end
  end

  always @(negedge tck)
    tdo_m <= (st == SHDR || st == SHIR) ? sr[0] : 1'b0;

  assign tdo = tie1 | tdo_m;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rlog_data [0:63];
  int          rlog_cyc  [0:63];
  int          rsp_cnt;
  always @(negedge clk) begin
    if (rsp_valid) begin
      rlog_data[rsp_cnt[5:0]] <= rsp_data;
      rlog_cyc[rsp_cnt[5:0]]  <= cyc;
      rsp_cnt <= rsp_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   rd;
  int   checks;
  int   failures;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input int len,
                      input logic [31:0] data, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < 2000), 64'(1));
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input int bits,
                      input int acc);
    exp_t e;
    e.data = d;
    e.lat  = 1 + 2 * CLK_DIV * bits;
    e.acc  = acc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      exp_t e;
      int   n;
      e = exp_q.pop_front();
      n = 0;
      while (rsp_cnt <= rd && n < 4000) begin
        @(posedge clk);
        n++;
      end
      chk({tag, "_rsp_seen"}, 64'(rsp_cnt > rd), 64'(1));
      if (rsp_cnt > rd) begin
        chk({tag, "_rsp_data"}, 64'(rlog_data[rd[5:0]]), 64'(e.data));
        chk({tag, "_latency"}, 64'(rlog_cyc[rd[5:0]] - e.acc),
            64'(e.lat));
        rd++;
      end
    end
  endtask

  task automatic chk_seq(input string tag, input int start,
                         input string tms_s, input logic [63:0] tdi_e);
    logic [63:0] ot, et, od;
    int n;
    n  = tms_s.len();
    ot = '0;
    et = '0;
    od = '0;
    chk({tag, "_ntck"}, 64'(tck_cnt - start), 64'(n));
    for (int i = 0; i < n; i++) begin
      ot[i] = tms_hist[10'(start + i)];
      od[i] = tdi_hist[10'(start + i)];
      et[i] = (tms_s[i] == "1");
    end
    chk({tag, "_tms"}, ot, et);
    chk({tag, "_tdi"}, od, tdi_e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    acc, acc2, t0, n, rc0;
    string s32;

    repeat (3) @(negedge clk);
    chk("reset_pins", 64'({tck, tms, tdi, trst_n, cmd_ready, rsp_valid}),
        64'(6'b010000));
    chk("reset_rsp_data", 64'(rsp_data), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_pins", 64'({trst_n, cmd_ready, tms}), 64'(3'b111));

    // DR scan straight out of TLR carries the prefix bit
    dr_cap = 32'h123456A5;
    t0 = tck_cnt;
    send(2'd2, 8, 32'h3C, acc);
    push(32'hA5, 14, acc);
    drain("dr8_pre");
    chk_seq("dr8_pre", t0, "01000000000110", 64'h3C << 4);
    chk("dr8_pre_tms_idle", 64'(tms), 64'(0));

    t0 = tck_cnt;
    send(2'd2, 8, 32'h3C, acc);
    push(32'hA5, 13, acc);
    drain("dr8");
    chk_seq("dr8", t0, "1000000000110", 64'h3C << 3);

    // fresh reset, then TAP reset command
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t0 = tck_cnt;
    send(2'd0, 0, 32'h0, acc);
    push(32'h0, 6, acc);
    drain("tlr");
    chk_seq("tlr", t0, "111110", 64'h0);
    repeat (5) @(negedge clk);
    chk("tlr_tms_hold", 64'(tms), 64'(0));
    chk("tlr_tap_rti", 64'(st == RTI), 64'(1));

    // IR scan, tdo tied high
    tie1 = 1'b1;
    t0 = tck_cnt;
    send(2'd1, 5, 32'h1, acc);
    push(32'h1F, 11, acc);
    drain("ir5");
    chk_seq("ir5", t0, "11000000110", 64'h1 << 4);
    tie1 = 1'b0;

    // full-width DR scan
    dr_cap = 32'hDEADBEEF;
    s32 = {"100", "0000000000", "0000000000", "0000000000", "0", "110"};
    t0 = tck_cnt;
    send(2'd2, 32, 32'h0, acc);
    push(32'hDEADBEEF, 37, acc);
    drain("dr32");
    chk_seq("dr32", t0, s32, 64'h0);

    // over-length request clamps to MAX_LEN
    t0 = tck_cnt;
    send(2'd2, 40, 32'h0, acc);
    push(32'hDEADBEEF, 37, acc);
    drain("dr_clamp");
    chk("dr_clamp_ntck", 64'(tck_cnt - t0), 64'(37));

    // reset asserted in the middle of bit 10
    t0 = tck_cnt;
    send(2'd2, 16, 32'hFFFF, acc);
    n = 0;
    while (tck_cnt < t0 + 10 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    while (tck && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("abort_reach_bit10", 64'(n < 2000), 64'(1));
    @(negedge clk);
    rc0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_pins", 64'({tck, tms, tdi, trst_n, cmd_ready, rsp_valid}),
        64'(6'b010000));
    chk("abort_rsp_data", 64'(rsp_data), 64'(0));
    chk("abort_tap_tlr", 64'(st == TLR), 64'(1));
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_rsp", 64'(rsp_cnt), 64'(rc0));
    t0 = tck_cnt;
    send(2'd0, 0, 32'h0, acc);
    push(32'h0, 6, acc);
    drain("abort_tlr");
    chk_seq("abort_tlr", t0, "111110", 64'h0);

    // cmd_valid held high across a busy idle command
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_len   = LEN_W'(4);
    cmd_data  = '0;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    push(32'h0, 4, acc);
    cmd_len = LEN_W'(2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    chk("b2b_rsp_cycle", 64'(rsp_valid), 64'(1));
    @(posedge clk);
    #1;
    acc2 = cyc;
    cmd_valid = 1'b0;
    push(32'h0, 2, acc2);
    chk("b2b_accept_gap", 64'(acc2 - acc), 64'(1 + 2 * CLK_DIV * 4 + 1));
    drain("b2b");

    // zero-length idle and zero-length scan
    t0 = tck_cnt;
    send(2'd3, 0, 32'h0, acc);
    push(32'h0, 0, acc);
    drain("idle0");
    chk("idle0_ntck", 64'(tck_cnt - t0), 64'(0));

    t0 = tck_cnt;
    send(2'd1, 0, 32'hFFFF_FFFF, acc);
    push(32'h0, 0, acc);
    drain("ir0");
    chk("ir0_ntck", 64'(tck_cnt - t0), 64'(0));

    repeat (10) @(negedge clk);
    chk("no_extra_rsp", 64'(rsp_cnt), 64'(rd));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
